// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between the instruction-fetch and data-access requesters.
// Build option ARB_FAIR_EN: a last-grant bit alternates grants when both sides keep requesting.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_If_Req,
  input  logic [DATA_WIDTH-1:0] i_If_Addr,
  output logic [DATA_WIDTH-1:0] o_If_Rdata,
  output logic                  o_If_Valid,
  input  logic                  i_Dm_Req,
  input  logic                  i_Dm_We,
  input  logic [DATA_WIDTH-1:0] i_Dm_Addr,
  input  logic [DATA_WIDTH-1:0] i_Dm_Wdata,
  output logic [DATA_WIDTH-1:0] o_Dm_Rdata,
  output logic                  o_Dm_Valid,
  input  logic                  i_Branch_Taken,
  output logic                  o_Freeze,
  output logic                  o_Pipe_Stall,
  output logic                  o_Mem_Req,
  output logic                  o_Mem_We,
  output logic [DATA_WIDTH-1:0] o_Mem_Addr,
  output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
  input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
  input  logic                  i_Mem_Ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic                    dm_valid_q, dm_valid_d;
  logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
  logic                    drop_q, drop_d;

  logic                    if_elig;
  logic                    dm_elig;
  logic                    data_first;
  logic                    grant_dm;
  logic                    grant_if;

`ifdef ARB_FAIR_EN
  logic                    last_dm_q, last_dm_d;

  always_comb begin
    data_first = ~last_dm_q;
    last_dm_d  = last_dm_q;
    if (grant_dm) begin
      last_dm_d = 1'b1;
    end else if (grant_if) begin
      last_dm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dm_q <= 1'b0;
    end else begin
      last_dm_q <= last_dm_d;
    end
  end
`else
  always_comb begin
    data_first = 1'b1;
  end
`endif

  // A held data request blocks fetch even during its own valid cycle, so a
  // continuously requesting data side keeps the port when it has priority.
  always_comb begin
    if_elig  = i_If_Req & ~if_valid_q;
    dm_elig  = i_Dm_Req & ~dm_valid_q;
    grant_dm = (state_q == IDLE) & dm_elig & (data_first | ~if_elig);
    grant_if = (state_q == IDLE) & if_elig & ~(i_Dm_Req & data_first);
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_valid_d  = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    drop_d      = drop_q;

    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_dm) begin
          state_d     = DM_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = i_Dm_We;
          mem_addr_d  = i_Dm_Addr;
          mem_wdata_d = i_Dm_Wdata;
        end else if (grant_if) begin
          state_d    = IF_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_If_Addr;
        end
      end

      IF_BUSY: begin
        if (i_Mem_Ready) begin
          // A flush on the completion cycle itself must also suppress the result.
          if (!(drop_q || i_Branch_Taken)) begin
            if_valid_d = 1'b1;
            if_rdata_d = i_Mem_Rdata;
          end
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          drop_d    = 1'b0;
        end else if (i_Branch_Taken) begin
          drop_d = 1'b1;
        end
      end

      DM_BUSY: begin
        if (i_Mem_Ready) begin
          dm_valid_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = i_Mem_Rdata;
          end
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_valid_q  <= dm_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    o_If_Valid   = if_valid_q;
    o_If_Rdata   = if_rdata_q;
    o_Dm_Valid   = dm_valid_q;
    o_Dm_Rdata   = dm_rdata_q;
    o_Mem_Req    = mem_req_q;
    o_Mem_We     = mem_we_q;
    o_Mem_Addr   = mem_addr_q;
    o_Mem_Wdata  = mem_wdata_q;
    o_Freeze     = i_If_Req & ~if_valid_q;
    o_Pipe_Stall = i_Dm_Req & ~dm_valid_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model with its own memory image,
// random requesters and a randomly delayed memory responder, plus directed scenarios.
module tb_mem_port_arbiter;
  localparam int DW = 32;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          i_If_Req, i_Dm_Req, i_Dm_We, i_Branch_Taken, i_Mem_Ready;
  logic [DW-1:0] i_If_Addr, i_Dm_Addr, i_Dm_Wdata, i_Mem_Rdata;
  logic          o_If_Valid, o_Dm_Valid, o_Freeze, o_Pipe_Stall, o_Mem_Req, o_Mem_We;
  logic [DW-1:0] o_If_Rdata, o_Dm_Rdata, o_Mem_Addr, o_Mem_Wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_If_Req(i_If_Req), .i_If_Addr(i_If_Addr), .o_If_Rdata(o_If_Rdata), .o_If_Valid(o_If_Valid),
    .i_Dm_Req(i_Dm_Req), .i_Dm_We(i_Dm_We), .i_Dm_Addr(i_Dm_Addr), .i_Dm_Wdata(i_Dm_Wdata),
    .o_Dm_Rdata(o_Dm_Rdata), .o_Dm_Valid(o_Dm_Valid), .i_Branch_Taken(i_Branch_Taken),
    .o_Freeze(o_Freeze), .o_Pipe_Stall(o_Pipe_Stall), .o_Mem_Req(o_Mem_Req), .o_Mem_We(o_Mem_We),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_Wdata(o_Mem_Wdata), .i_Mem_Rdata(i_Mem_Rdata),
    .i_Mem_Ready(i_Mem_Ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory images (responder side and model side kept apart)
  logic [DW-1:0] resp_mem  [logic [DW-1:0]];
  logic [DW-1:0] model_mem [logic [DW-1:0]];

  function automatic logic [DW-1:0] dflt(input logic [DW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [DW-1:0] resp_rd(input logic [DW-1:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : dflt(a);
  endfunction
  function automatic logic [DW-1:0] model_rd(input logic [DW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction
  task automatic preload(input logic [DW-1:0] a, input logic [DW-1:0] d);
    resp_mem[a]  = d;
    model_mem[a] = d;
  endtask

  // ---------------- behavioural model: who owns the port and what is owed to whom
  typedef enum int {NOBODY, FETCH, DATA} owner_e;
  owner_e        m_owner;
  bit            m_drop, m_last_dm, m_req, m_we, m_if_v, m_dm_v;
  logic [DW-1:0] m_addr, m_wdata, m_if_rd, m_dm_rd;

  task automatic model_reset();
    m_owner = NOBODY; m_drop = 0; m_last_dm = 0; m_req = 0; m_we = 0;
    m_if_v = 0; m_dm_v = 0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
  endtask

  task automatic model_step();
    bit nif, ndm, if_ok, dm_ok, data_first;
    nif = 0; ndm = 0;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_owner)
      NOBODY: begin
        if_ok      = i_If_Req && !m_if_v;
        dm_ok      = i_Dm_Req && !m_dm_v;
        data_first = FAIR ? !m_last_dm : 1'b1;
        if (dm_ok && (data_first || !if_ok)) begin
          m_owner = DATA; m_req = 1; m_we = i_Dm_We; m_addr = i_Dm_Addr; m_wdata = i_Dm_Wdata;
          m_last_dm = 1;
        end else if (if_ok && !(i_Dm_Req && data_first)) begin
          m_owner = FETCH; m_req = 1; m_we = 0; m_addr = i_If_Addr; m_last_dm = 0;
        end
      end
      FETCH: begin
        if (i_Mem_Ready) begin
          if (!(m_drop || i_Branch_Taken)) begin
            nif = 1; m_if_rd = model_rd(m_addr);
          end
          m_owner = NOBODY; m_req = 0; m_drop = 0;
        end else if (i_Branch_Taken) begin
          m_drop = 1;
        end
      end
      DATA: begin
        if (i_Mem_Ready) begin
          ndm = 1;
          if (m_we) model_mem[m_addr] = m_wdata;
          else      m_dm_rd = model_rd(m_addr);
          m_owner = NOBODY; m_req = 0; m_we = 0;
        end
      end
      default: ;
    endcase
    m_if_v = nif;
    m_dm_v = ndm;
  endtask

  task automatic check_all();
    chk("if_valid",   o_If_Valid,   m_if_v);
    chk("dm_valid",   o_Dm_Valid,   m_dm_v);
    chk("if_rdata",   o_If_Rdata,   m_if_rd);
    chk("dm_rdata",   o_Dm_Rdata,   m_dm_rd);
    chk("mem_req",    o_Mem_Req,    m_req);
    chk("mem_we",     o_Mem_We,     m_we);
    chk("mem_addr",   o_Mem_Addr,   m_addr);
    chk("mem_wdata",  o_Mem_Wdata,  m_wdata);
    chk("freeze",     o_Freeze,     i_If_Req && !m_if_v);
    chk("pipe_stall", o_Pipe_Stall, i_Dm_Req && !m_dm_v);
  endtask

  // ---------------- memory responder
  bit resp_auto = 1, spur_en = 0;
  int resp_cnt = 0, resp_lat = 1, lat_min = 1, lat_max = 1;

  task automatic responder();
    if (!resp_auto) return;
    if (i_Mem_Ready) begin
      i_Mem_Ready = 0; resp_cnt = 0; i_Mem_Rdata = $urandom;
    end else if (o_Mem_Req) begin
      if (resp_cnt == 0) resp_lat = $urandom_range(lat_max, lat_min);
      resp_cnt++;
      if (resp_cnt >= resp_lat) begin
        i_Mem_Ready = 1;
        i_Mem_Rdata = o_Mem_We ? $urandom : resp_rd(o_Mem_Addr);
        if (o_Mem_We) resp_mem[o_Mem_Addr] = o_Mem_Wdata;
      end else begin
        i_Mem_Rdata = $urandom;
      end
    end else begin
      resp_cnt = 0; i_Mem_Rdata = $urandom;
      if (spur_en && $urandom_range(0, 5) == 0) i_Mem_Ready = 1;
    end
  endtask

  bit prev_mem_req = 0;
  bit dut_grants[$];   // 1 = data grant (data addresses carry the top bit)

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (o_Mem_Req && !prev_mem_req) dut_grants.push_back(o_Mem_Addr[DW-1]);
    prev_mem_req = o_Mem_Req;
    responder();
    @(negedge clk);
    check_all();
  endtask

  // ---------------- requester agents
  int if_mode = 0, dm_mode = 0, if_done = 0, dm_done = 0;
  bit br_en = 0;

  function automatic logic [DW-1:0] rand_if_addr();
    return 32'h0000_1000 | ($urandom & 32'h0000_00FC);
  endfunction
  function automatic logic [DW-1:0] rand_dm_addr();
    return 32'h8000_0000 | ($urandom & 32'h0000_003C);
  endfunction

  task automatic agents_step();
    i_Branch_Taken = 0;
    if (br_en && $urandom_range(0, 11) == 0) begin
      i_Branch_Taken = 1;
      if (i_If_Req) i_If_Addr = rand_if_addr();
    end
    if (i_If_Req) begin
      if (o_If_Valid) begin
        if_done++;
        if (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 1) == 1)) i_If_Addr = rand_if_addr();
        else i_If_Req = 0;
      end
    end else if (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 3) == 0)) begin
      i_If_Req = 1; i_If_Addr = rand_if_addr();
    end
    if (i_Dm_Req) begin
      if (o_Dm_Valid) begin
        dm_done++;
        if (dm_mode == 2 || (dm_mode == 1 && $urandom_range(0, 1) == 1)) begin
          i_Dm_Addr = rand_dm_addr(); i_Dm_We = $urandom_range(0, 1); i_Dm_Wdata = $urandom;
        end else i_Dm_Req = 0;
      end
    end else if (dm_mode == 2 || (dm_mode == 1 && $urandom_range(0, 3) == 0)) begin
      i_Dm_Req = 1; i_Dm_Addr = rand_dm_addr(); i_Dm_We = $urandom_range(0, 1); i_Dm_Wdata = $urandom;
    end
  endtask

  task automatic drain(input string name);
    if_mode = 0; dm_mode = 0; br_en = 0; i_Branch_Taken = 0;
    for (int k = 0; k < 200 && (i_If_Req || i_Dm_Req || o_Mem_Req); k++) begin
      cycle();
      agents_step();
    end
    chk(name, {i_If_Req, i_Dm_Req, o_Mem_Req}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fz, got, dm_at, if_at, frz_drop, saw2000, n_if_g, n_dm_g, alt_ok;
    reset = 1; model_reset();
    i_If_Req = 0; i_If_Addr = '0; i_Dm_Req = 0; i_Dm_We = 0; i_Dm_Addr = '0; i_Dm_Wdata = '0;
    i_Branch_Taken = 0; i_Mem_Ready = 0; i_Mem_Rdata = '0;
    cycle(); cycle();
    chk("rst_mem_req", o_Mem_Req, 0);
    chk("rst_if_valid", o_If_Valid, 0);
    chk("rst_mem_addr", o_Mem_Addr, 0);
    reset = 0;

    // fetch 0x4, ready two cycles after the request is issued
    preload(32'h4, 32'hE3A01001);
    lat_min = 2; lat_max = 2;
    i_If_Addr = 32'h4; i_If_Req = 1; #1;
    fz = 0; got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      if (o_Freeze) fz++;
      cycle();
      if (o_If_Valid) got = 1;
    end
    chk("t34_valid_seen", got, 1);
    chk("t34_if_rdata", o_If_Rdata, 32'hE3A01001);
    chk("t34_model_rdata", m_if_rd, 32'hE3A01001);
    chk("t34_freeze_cycles", fz, 3);
    i_If_Req = 0;
    cycle();
    chk("t34_single_pulse", o_If_Valid, 0);

    // simultaneous fetch and data read: data first, freeze held throughout
    preload(32'h100, 32'hCAFEF00D); preload(32'h8, 32'h0BADC0DE);
    lat_min = 1; lat_max = 1;
    i_Dm_Req = 1; i_Dm_We = 0; i_Dm_Addr = 32'h100; i_If_Req = 1; i_If_Addr = 32'h8;
    dm_at = -1; if_at = -1; frz_drop = 0;
    for (int k = 0; k < 40 && if_at < 0; k++) begin
      cycle();
      if (!o_Freeze && !o_If_Valid) frz_drop++;
      if (o_Dm_Valid && dm_at < 0) begin
        dm_at = k; chk("t35_dm_rdata", o_Dm_Rdata, 32'hCAFEF00D); i_Dm_Req = 0;
      end
      if (o_If_Valid) begin
        if_at = k; chk("t35_if_rdata", o_If_Rdata, 32'h0BADC0DE);
      end
    end
    chk("t35_data_before_fetch", (dm_at >= 0) && (if_at > dm_at), 1);
    chk("t35_freeze_held", frz_drop, 0);
    i_If_Req = 0;
    cycle();

    // flush during an outstanding fetch of 0x1000, then fetch 0x2000
    preload(32'h1000, 32'h11111111); preload(32'h2000, 32'h12345678);
    lat_min = 3; lat_max = 3;
    i_If_Req = 1; i_If_Addr = 32'h1000;
    for (int k = 0; k < 10 && !o_Mem_Req; k++) cycle();
    chk("t36_first_addr", o_Mem_Addr, 32'h1000);
    i_Branch_Taken = 1; i_If_Addr = 32'h2000;
    cycle();
    i_Branch_Taken = 0;
    got = 0; saw2000 = 0;
    for (int k = 0; k < 30 && got == 0; k++) begin
      cycle();
      if (o_Mem_Req && o_Mem_Addr == 32'h2000) saw2000 = 1;
      if (o_If_Valid) begin
        got = 1; chk("t36_if_rdata", o_If_Rdata, 32'h12345678);
      end
    end
    chk("t36_refetch_issued", saw2000, 1);
    chk("t36_valid_seen", got, 1);
    i_If_Req = 0;
    cycle();

    // write 0xDEADBEEF to 0x200, then read it back
    i_Dm_Req = 1; i_Dm_We = 1; i_Dm_Addr = 32'h200; i_Dm_Wdata = 32'hDEADBEEF;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      cycle();
      if (o_Mem_Req) begin
        chk("t39_we", o_Mem_We, 1);
        chk("t39_addr", o_Mem_Addr, 32'h200);
        chk("t39_wdata", o_Mem_Wdata, 32'hDEADBEEF);
        chk("t39_stall_high", o_Pipe_Stall, 1);
      end
      if (o_Dm_Valid) begin
        got = 1; chk("t39_stall_drop", o_Pipe_Stall, 0);
      end
    end
    chk("t39_valid_seen", got, 1);
    i_Dm_Req = 0;
    cycle();
    chk("t39_single_pulse", o_Dm_Valid, 0);
    i_Dm_Req = 1; i_Dm_We = 0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      cycle();
      if (o_Dm_Valid) got = 1;
    end
    chk("t39_readback", o_Dm_Rdata, 32'hDEADBEEF);
    i_Dm_Req = 0;
    cycle();

    // reset while a data read is outstanding, then a stale ready
    resp_auto = 0; i_Mem_Ready = 0;
    i_Dm_Req = 1; i_Dm_We = 0; i_Dm_Addr = 32'h300;
    cycle(); cycle();
    chk("t38_busy_before", o_Mem_Req, 1);
    i_Dm_Req = 0;
    #2 reset = 1; model_reset();
    #1;
    chk("t38_mem_req", o_Mem_Req, 0);
    chk("t38_mem_we", o_Mem_We, 0);
    chk("t38_mem_addr", o_Mem_Addr, 0);
    chk("t38_dm_rdata", o_Dm_Rdata, 0);
    chk("t38_if_rdata", o_If_Rdata, 0);
    chk("t38_dm_valid", o_Dm_Valid, 0);
    cycle();
    reset = 0;
    i_Mem_Ready = 1;
    cycle();
    i_Mem_Ready = 0;
    cycle();
    chk("t38_no_stale_valid", o_Dm_Valid, 0);
    chk("t38_idle", o_Mem_Req, 0);
    resp_auto = 1;

    // both sides requesting continuously
    lat_min = 1; lat_max = 1; spur_en = 0;
    dut_grants.delete();
    if_mode = 2; dm_mode = 2;
    for (int k = 0; k < 40; k++) begin
      cycle();
      agents_step();
    end
    n_if_g = 0; n_dm_g = 0; alt_ok = 1;
    foreach (dut_grants[k]) begin
      if (dut_grants[k]) n_dm_g++; else n_if_g++;
      if (k > 0 && dut_grants[k] == dut_grants[k-1]) alt_ok = 0;
    end
`ifdef ARB_FAIR_EN
    chk("t37_alternating", alt_ok, 1);
    chk("t37_if_granted", n_if_g >= 4, 1);
`else
    chk("t37_no_if_grant", n_if_g, 0);
    chk("t37_dm_granted", n_dm_g >= 5, 1);
`endif
    drain("t37_drain");

    // random traffic with flushes, variable latency and stray ready pulses
    lat_min = 1; lat_max = 4; spur_en = 1; br_en = 1;
    if_mode = 1; dm_mode = 1; if_done = 0; dm_done = 0;
    for (int k = 0; k < 1500; k++) begin
      cycle();
      agents_step();
    end
    drain("rand_drain");
    chk("rand_if_served", if_done > 10, 1);
    chk("rand_dm_served", dm_done > 10, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
